// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } op_e;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StFix, StResp} state_t;

    typedef enum logic [2:0] {ClsMulSs, ClsMulSu, ClsMulUu, ClsDivS, ClsDivU} cls_e;

    localparam logic [31:0] IntMin  = 32'h8000_0000;
    localparam logic [31:0] AllOnes = 32'hFFFF_FFFF;

    function automatic logic rs1_signed(input op_e op);
        return op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
    endfunction

    function automatic logic rs2_signed(input op_e op);
        return op inside {OpMulh, OpDiv, OpRem};
    endfunction

    // MUL keeps only the low word, which is sign-agnostic, so it is filed as unsigned.
    function automatic cls_e op_class(input op_e op);
        case (op)
            OpMulh:         return ClsMulSs;
            OpMulhsu:       return ClsMulSu;
            OpMul, OpMulhu: return ClsMulUu;
            OpDiv, OpRem:   return ClsDivS;
            default:        return ClsDivU;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; yields |x| for operands and the
// sign-corrected result in the fix-up stage.
module muldiv_signfix #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] value,
    input  logic             negate,
    output logic [Width-1:0] result
);

    assign result = negate ? -value : value;

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M sequencer in front of the iterative unsigned multiply/divide unit.
// Optional one-entry result cache enabled by defining MULDIV_FUSE_EN.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    input  logic        req_kill,
    output logic        rsp_valid,
    input  logic        rsp_stall,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        core_start,
    output logic        core_is_div,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic        core_flush,
    input  logic        core_done,
    input  logic [31:0] core_hi,
    input  logic [31:0] core_lo
);

    state_t      state_q, state_d;
    op_e         op_q;
    logic [4:0]  rd_q;
    logic        a_neg_q, b_neg_q;
    logic [63:0] res_q;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [4:0]  rsp_rd_q, rsp_rd_d;
    logic        core_start_q, core_start_d, core_flush_q, core_flush_d;
    logic        core_is_div_q;
    logic [31:0] core_a_q, core_b_q;

    op_e         req_op_e;
    logic        accept, special, hit;
    logic        a_neg_in, b_neg_in;
    logic [31:0] a_mag, b_mag, special_data;
    logic [63:0] hit_res, prod_fix, fixed;
    logic [31:0] quo_fix, rem_fix, fix_data;

    assign req_op_e  = op_e'(req_op);
    assign req_ready = (state_q == StIdle);
    assign accept    = req_valid && req_ready && !req_kill;
    assign a_neg_in  = rs1_signed(req_op_e) && req_rs1[31];
    assign b_neg_in  = rs2_signed(req_op_e) && req_rs2[31];

    muldiv_signfix #(.Width(32)) u_mag_a (.value(req_rs1), .negate(a_neg_in), .result(a_mag));
    muldiv_signfix #(.Width(32)) u_mag_b (.value(req_rs2), .negate(b_neg_in), .result(b_mag));

    // Divide by zero and INT_MIN / -1 are answered without the unit.
    always_comb begin
        special      = 1'b0;
        special_data = '0;
        if (req_op[2]) begin
            if (req_rs2 == '0) begin
                special      = 1'b1;
                special_data = req_op[1] ? req_rs1 : AllOnes;
            end else if (!req_op[0] && req_rs1 == IntMin && req_rs2 == AllOnes) begin
                special      = 1'b1;
                special_data = req_op[1] ? 32'h0 : IntMin;
            end
        end
    end

    muldiv_signfix #(.Width(64)) u_fix_prod (
        .value(res_q), .negate(a_neg_q ^ b_neg_q), .result(prod_fix)
    );
    muldiv_signfix #(.Width(32)) u_fix_quo (
        .value(res_q[31:0]), .negate(a_neg_q ^ b_neg_q), .result(quo_fix)
    );
    muldiv_signfix #(.Width(32)) u_fix_rem (
        .value(res_q[63:32]), .negate(a_neg_q), .result(rem_fix)
    );

    assign fixed    = core_is_div_q ? {rem_fix, quo_fix} : prod_fix;
    assign fix_data = (op_q inside {OpMul, OpDiv, OpDivu}) ? fixed[31:0] : fixed[63:32];

`ifdef MULDIV_FUSE_EN
    logic        cache_valid_q, hit_q;
    cls_e        cache_cls_q;
    logic [31:0] cache_rs1_q, cache_rs2_q, rs1_q, rs2_q;
    logic [63:0] cache_res_q;

    assign hit = cache_valid_q && cache_rs1_q == req_rs1 && cache_rs2_q == req_rs2 &&
                 (cache_cls_q == op_class(req_op_e) ||
                  (req_op_e == OpMul && cache_cls_q inside {ClsMulSs, ClsMulSu, ClsMulUu}));
    assign hit_res = cache_res_q;

    // A hit replays through FIX; it must not overwrite the entry under a different class.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cache_valid_q <= 1'b0;
            hit_q         <= 1'b0;
            cache_cls_q   <= ClsMulUu;
            cache_rs1_q   <= '0;
            cache_rs2_q   <= '0;
            cache_res_q   <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
        end else begin
            if (accept) begin
                hit_q <= hit;
                rs1_q <= req_rs1;
                rs2_q <= req_rs2;
            end
            if (req_kill || (accept && special)) begin
                cache_valid_q <= 1'b0;
            end else if (state_q == StFix && !hit_q) begin
                cache_valid_q <= 1'b1;
                cache_cls_q   <= op_class(op_q);
                cache_rs1_q   <= rs1_q;
                cache_rs2_q   <= rs2_q;
                cache_res_q   <= fixed;
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = special ? StResp : (hit ? StFix : StIssue);
            StIssue: state_d = StWait;
            StWait:  if (core_done) state_d = StFix;
            StFix:   state_d = StResp;
            StResp:  if (!rsp_stall) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (req_kill) state_d = StIdle;
    end

    always_comb begin
        rsp_valid_d  = (state_d == StResp);
        core_start_d = (state_d == StIssue);
        core_flush_d = req_kill && (state_q inside {StIssue, StWait});
        rsp_data_d   = rsp_data_q;
        rsp_rd_d     = rsp_rd_q;
        if (state_d == StResp && state_q != StResp) begin
            rsp_data_d = (state_q == StIdle) ? special_data : fix_data;
            rsp_rd_d   = (state_q == StIdle) ? req_rd : rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_rd_q     <= '0;
            core_start_q <= 1'b0;
            core_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_rd_q     <= rsp_rd_d;
            core_start_q <= core_start_d;
            core_flush_q <= core_flush_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_q          <= OpMul;
            rd_q          <= '0;
            a_neg_q       <= 1'b0;
            b_neg_q       <= 1'b0;
            core_is_div_q <= 1'b0;
            core_a_q      <= '0;
            core_b_q      <= '0;
            res_q         <= '0;
        end else begin
            if (accept) begin
                op_q          <= req_op_e;
                rd_q          <= req_rd;
                a_neg_q       <= a_neg_in && !hit;
                b_neg_q       <= b_neg_in && !hit;
                core_is_div_q <= req_op[2];
                core_a_q      <= a_mag;
                core_b_q      <= b_mag;
            end
            if (accept && hit) begin
                res_q <= hit_res;
            end else if (state_q == StWait && core_done && !req_kill) begin
                res_q <= {core_hi, core_lo};
            end
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_rd      = rsp_rd_q;
    assign core_start  = core_start_q;
    assign core_flush  = core_flush_q;
    assign core_is_div = core_is_div_q;
    assign core_a      = core_a_q;
    assign core_b      = core_b_q;

endmodule
